// File: rtl/abacus_event_counter_bank.sv
// Wishbone-mapped bank of per-channel event counters with coherent hi/lo reads and sticky overflow flags.
// Optional overflow interrupt (irq port + IRQ_MASK register) is built when ABACUS_OVF_IRQ_EN is defined.
module abacus_event_counter_bank #(
    parameter logic [31:0] BASE_ADDR     = 32'hf0040000,
    parameter int          NUM_CHANNELS  = 16,
    parameter int          COUNTER_WIDTH = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CHANNELS-1:0] evt,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [31:0]             wb_adr,
    input  logic [31:0]             wb_dat_i,
    output logic [31:0]             wb_dat_o,
    output logic                    wb_ack
`ifdef ABACUS_OVF_IRQ_EN
    ,
    output logic                    irq
`endif
);

    localparam logic [31:0] CNT_BASE = 32'h100;
    localparam logic [31:0] CNT_END  = 32'h100 + 32'(8 * NUM_CHANNELS);

    logic                    global_en;
    logic                    freeze;
    logic [NUM_CHANNELS-1:0] ch_en;
    logic [NUM_CHANNELS-1:0] ovf;
    logic [NUM_CHANNELS-1:0] evt_q;
    logic [31:0]             snap;

    logic [31:0] off;
    logic [31:0] cnt_off;
    logic [31:0] ch_sel;
    logic        sel_ctrl;
    logic        sel_chen;
    logic        sel_ovf;
    logic        sel_mask;
    logic        sel_cnt;
    logic        sel_hi;
    logic        access;
    logic        wr;
    logic        clear_all;
    logic [NUM_CHANNELS-1:0] w1c;
    logic [NUM_CHANNELS-1:0] inc;
    logic [NUM_CHANNELS-1:0] wrap;
    logic [63:0]             cnt_ext [NUM_CHANNELS];
    logic [31:0] rd_lo;
    logic [31:0] rd_hi;
    logic [31:0] rd_data;
    logic [31:0] mask_rd;
    logic        unused_bits;

    assign off      = wb_adr - BASE_ADDR;
    assign cnt_off  = off - CNT_BASE;
    assign ch_sel   = {3'b000, cnt_off[31:3]};
    assign sel_ctrl = (off == 32'h000);
    assign sel_chen = (off == 32'h004);
    assign sel_ovf  = (off == 32'h008);
    assign sel_mask = (off == 32'h00c);
    assign sel_cnt  = (off >= CNT_BASE) && (off < CNT_END) && (off[1:0] == 2'b00);
    assign sel_hi   = off[2];

    assign access    = wb_cyc & wb_stb & ~wb_ack;
    assign wr        = access & wb_we;
    assign clear_all = wr & sel_ctrl & wb_dat_i[2];
    assign w1c       = (wr & sel_ovf) ? wb_dat_i[NUM_CHANNELS-1:0] : '0;
    assign unused_bits = ^{wb_dat_i, cnt_off[2:0]};

    // Each counter lives in its own scope; a clear on the same edge swallows any pending increment.
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic [COUNTER_WIDTH-1:0] cnt;

        assign inc[g]     = evt_q[g] & global_en & ch_en[g] & ~freeze & ~clear_all;
        assign wrap[g]    = inc[g] & (&cnt);
        assign cnt_ext[g] = 64'(cnt);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (clear_all) begin
                cnt <= '0;
            end else if (inc[g]) begin
                cnt <= cnt + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef ABACUS_OVF_IRQ_EN
    logic [NUM_CHANNELS-1:0] irq_mask;
    assign mask_rd = 32'(irq_mask);
`else
    assign mask_rd = '0;
`endif

    always_comb begin
        rd_lo   = '0;
        rd_hi   = '0;
        rd_data = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (ch_sel == 32'(i)) begin
                rd_lo = cnt_ext[i][31:0];
                rd_hi = cnt_ext[i][63:32];
            end
        end
        if (sel_ctrl)      rd_data = {30'd0, freeze, global_en};
        else if (sel_chen) rd_data = 32'(ch_en);
        else if (sel_ovf)  rd_data = 32'(ovf);
        else if (sel_mask) rd_data = mask_rd;
        else if (sel_cnt)  rd_data = sel_hi ? snap : rd_lo;
    end

    // Bus side: a LO read latches the same counter's pre-increment high bits so a later HI read matches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack    <= 1'b0;
            wb_dat_o  <= '0;
            global_en <= 1'b0;
            freeze    <= 1'b0;
            ch_en     <= '0;
            ovf       <= '0;
            evt_q     <= '0;
            snap      <= '0;
        end else begin
            wb_ack <= access;
            evt_q  <= evt;
            ovf    <= (ovf & ~w1c) | wrap;
            if (access) begin
                wb_dat_o <= wb_we ? '0 : rd_data;
            end
            if (wr && sel_ctrl) begin
                global_en <= wb_dat_i[0];
                freeze    <= wb_dat_i[1];
            end
            if (wr && sel_chen) begin
                ch_en <= wb_dat_i[NUM_CHANNELS-1:0];
            end
            if (access && !wb_we && sel_cnt && !sel_hi) begin
                snap <= rd_hi;
            end
        end
    end

`ifdef ABACUS_OVF_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr && sel_mask) begin
                irq_mask <= wb_dat_i[NUM_CHANNELS-1:0];
            end
            irq <= |(ovf & irq_mask);
        end
    end
`endif

endmodule

// File: tb/tb_abacus_event_counter_bank.sv
// Directed self-checking bench for abacus_event_counter_bank (default 16 channels x 48 bits).
// Counters are preloaded near their wrap points with force/release to avoid billions of events.
module tb_abacus_event_counter_bank;

    localparam logic [31:0] BASE   = 32'hf0040000;
    localparam logic [31:0] A_CTRL = BASE + 32'h000;
    localparam logic [31:0] A_CHEN = BASE + 32'h004;
    localparam logic [31:0] A_OVF  = BASE + 32'h008;
    localparam logic [31:0] A_MASK = BASE + 32'h00c;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] evt = '0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
`ifdef ABACUS_OVF_IRQ_EN
    logic        irq;
`endif

    int compared = 0;
    int mismatched = 0;

    abacus_event_counter_bank #(
        .BASE_ADDR(BASE),
        .NUM_CHANNELS(16),
        .COUNTER_WIDTH(48)
    ) dut (
        .clk(clk),
        .rst(rst),
        .evt(evt),
        .wb_cyc(wb_cyc),
        .wb_stb(wb_stb),
        .wb_we(wb_we),
        .wb_adr(wb_adr),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_ack(wb_ack)
`ifdef ABACUS_OVF_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lo_addr(input int ch);
        return BASE + 32'h100 + 32'(8 * ch);
    endfunction

    function automatic logic [31:0] hi_addr(input int ch);
        return BASE + 32'h104 + 32'(8 * ch);
    endfunction

    // Bus tasks are entered just after a falling edge; they return one cycle after the ack pulse.
    task automatic wb_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic ack_on, output logic ack_after);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = addr;
        @(posedge clk); @(negedge clk);
        ack_on = wb_ack;
        data   = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk); @(negedge clk);
        ack_after = wb_ack;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        logic a0, a1;
        wb_read(addr, data, a0, a1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = addr; wb_dat_i = data;
        @(posedge clk); @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] addrs [4];
        logic [31:0] d;
        logic a_on, a_after;
        addrs = '{A_CTRL, A_CHEN, A_OVF, BASE + 32'h100};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        compared++; if (wb_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ack: got %b expected 0", wb_ack); end
        compared++; if (wb_dat_o !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_dat: got %h expected 0", wb_dat_o); end
`ifdef ABACUS_OVF_IRQ_EN
        compared++; if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
`endif
        for (int i = 0; i < 4; i++) begin
            wb_read(addrs[i], d, a_on, a_after);
            compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_reg%0d: got %h expected 0", i, d); end
            compared++; if (a_on !== 1'b1) begin mismatched++; $display("[TB] FAIL ack_pulse%0d: got %b expected 1", i, a_on); end
            compared++; if (a_after !== 1'b0) begin mismatched++; $display("[TB] FAIL ack_single%0d: got %b expected 0", i, a_after); end
        end
    endtask

    task automatic test_counting();
        logic [31:0] d;
        logic [31:0] exp_cnt [4];
        exp_cnt = '{32'd10, 32'd0, 32'd10, 32'd0};
        wr(A_CTRL, 32'h1);
        wr(A_CHEN, 32'h5);
        evt = 16'h000f;
        repeat (10) @(negedge clk);
        evt = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rd(lo_addr(i), d);
            compared++; if (d !== exp_cnt[i]) begin mismatched++; $display("[TB] FAIL count_ch%0d: got %0d expected %0d", i, d, exp_cnt[i]); end
        end
    endtask

    task automatic test_hi_lo();
        logic [31:0] d;
        wr(A_CHEN, 32'h000f);
        force dut.g_ch[3].cnt = 48'h0000_ffff_ffff;
        evt[3] = 1'b1;
        #1 release dut.g_ch[3].cnt;
        @(negedge clk);
        evt[3] = 1'b0;
        repeat (2) @(negedge clk);
        rd(lo_addr(3), d);
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL carry_lo: got %h expected 0", d); end
        rd(hi_addr(3), d);
        compared++; if (d !== 32'h1) begin mismatched++; $display("[TB] FAIL carry_hi: got %h expected 1", d); end
        rd(A_OVF, d);
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL carry_ovf: got %h expected 0", d); end

        // Counter keeps running through a 32-bit carry while LO/HI pairs are read.
        force dut.g_ch[3].cnt = 48'h0001_ffff_ffff;
        evt[3] = 1'b1;
        #1 release dut.g_ch[3].cnt;
        rd(lo_addr(3), d);
        compared++; if (d !== 32'hffff_ffff) begin mismatched++; $display("[TB] FAIL coh_lo1: got %h expected ffffffff", d); end
        rd(hi_addr(3), d);
        compared++; if (d !== 32'h1) begin mismatched++; $display("[TB] FAIL coh_hi1: got %h expected 1", d); end
        rd(lo_addr(3), d);
        compared++; if (d !== 32'h2) begin mismatched++; $display("[TB] FAIL coh_lo2: got %h expected 2", d); end
        rd(hi_addr(3), d);
        compared++; if (d !== 32'h2) begin mismatched++; $display("[TB] FAIL coh_hi2: got %h expected 2", d); end
        evt[3] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        force dut.g_ch[0].cnt = 48'hffff_ffff_ffff;
        evt[0] = 1'b1;
        #1 release dut.g_ch[0].cnt;
        @(negedge clk);
        evt[0] = 1'b0;
        repeat (2) @(negedge clk);
        rd(lo_addr(0), d);
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL wrap_lo: got %h expected 0", d); end
        rd(hi_addr(0), d);
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL wrap_hi: got %h expected 0", d); end
        rd(A_OVF, d);
        compared++; if (d !== 32'h1) begin mismatched++; $display("[TB] FAIL ovf_set: got %h expected 1", d); end

        // W1C lands on the very edge of a second wrap; the set must win.
        force dut.g_ch[0].cnt = 48'hffff_ffff_ffff;
        evt[0] = 1'b1;
        #1 release dut.g_ch[0].cnt;
        @(negedge clk);
        evt[0] = 1'b0;
        wr(A_OVF, 32'h1);
        rd(A_OVF, d);
        compared++; if (d !== 32'h1) begin mismatched++; $display("[TB] FAIL ovf_set_wins: got %h expected 1", d); end
        rd(lo_addr(0), d);
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL wrap2_lo: got %h expected 0", d); end
        wr(A_OVF, 32'h1);
        rd(A_OVF, d);
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL ovf_w1c: got %h expected 0", d); end
    endtask

    task automatic test_freeze_clear();
        logic [31:0] d;
        wr(A_CHEN, 32'hffff);
        wr(A_CTRL, 32'h3);
        rd(A_CTRL, d);
        compared++; if (d !== 32'h3) begin mismatched++; $display("[TB] FAIL ctrl_rb: got %h expected 3", d); end
        evt = 16'hffff;
        repeat (20) @(negedge clk);
        evt = '0;
        repeat (2) @(negedge clk);
        rd(lo_addr(2), d);
        compared++; if (d !== 32'd10) begin mismatched++; $display("[TB] FAIL frz_ch2: got %0d expected 10", d); end
        rd(lo_addr(0), d);
        compared++; if (d !== 32'd0) begin mismatched++; $display("[TB] FAIL frz_ch0: got %0d expected 0", d); end
        rd(lo_addr(15), d);
        compared++; if (d !== 32'd0) begin mismatched++; $display("[TB] FAIL frz_ch15: got %0d expected 0", d); end

        wr(A_CTRL, 32'h1);
        evt = 16'hffff;
        repeat (5) @(negedge clk);
        evt = '0;
        repeat (2) @(negedge clk);
        rd(lo_addr(1), d);
        compared++; if (d !== 32'd5) begin mismatched++; $display("[TB] FAIL run_ch1: got %0d expected 5", d); end
        rd(lo_addr(2), d);
        compared++; if (d !== 32'd15) begin mismatched++; $display("[TB] FAIL run_ch2: got %0d expected 15", d); end

        // CLEAR_ALL lands while the last sampled event is still in flight.
        evt = 16'hffff;
        repeat (3) @(negedge clk);
        evt = '0;
        wr(A_CTRL, 32'h5);
        rd(A_CTRL, d);
        compared++; if (d !== 32'h1) begin mismatched++; $display("[TB] FAIL clr_ctrl: got %h expected 1", d); end
        for (int i = 1; i < 16; i += 7) begin
            rd(lo_addr(i), d);
            compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL clr_ch%0d: got %h expected 0", i, d); end
        end
        rd(hi_addr(15), d);
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL clr_hi: got %h expected 0", d); end
    endtask

    task automatic test_bus_map();
        logic [31:0] d;
        logic a_on, a_after;
        wb_read(BASE + 32'h200, d, a_on, a_after);
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL unmapped_dat: got %h expected 0", d); end
        compared++; if (a_on !== 1'b1) begin mismatched++; $display("[TB] FAIL unmapped_ack: got %b expected 1", a_on); end
        wr(lo_addr(2), 32'h1234);
        rd(lo_addr(2), d);
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL cnt_wr_ignored: got %h expected 0", d); end
        wr(A_CHEN, 32'hffff_ffff);
        rd(A_CHEN, d);
        compared++; if (d !== 32'h0000_ffff) begin mismatched++; $display("[TB] FAIL chen_upper: got %h expected 0000ffff", d); end
        wr(A_MASK, 32'h1);
        rd(A_MASK, d);
`ifdef ABACUS_OVF_IRQ_EN
        compared++; if (d !== 32'h1) begin mismatched++; $display("[TB] FAIL mask_rb: got %h expected 1", d); end
`else
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL mask_rb: got %h expected 0", d); end
`endif
        wr(A_MASK, 32'h0);
    endtask

`ifdef ABACUS_OVF_IRQ_EN
    task automatic test_irq();
        logic [31:0] d;
        wr(A_MASK, 32'h1);
        force dut.g_ch[0].cnt = 48'hffff_ffff_ffff;
        evt[0] = 1'b1;
        #1 release dut.g_ch[0].cnt;
        @(negedge clk);
        evt[0] = 1'b0;
        @(negedge clk);
        compared++; if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_latency: got %b expected 0", irq); end
        @(negedge clk);
        compared++; if (irq !== 1'b1) begin mismatched++; $display("[TB] FAIL irq_assert: got %b expected 1", irq); end
        wr(A_MASK, 32'h0);
        compared++; if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_masked: got %b expected 0", irq); end
        wr(A_OVF, 32'h1);
        force dut.g_ch[1].cnt = 48'hffff_ffff_ffff;
        evt[1] = 1'b1;
        #1 release dut.g_ch[1].cnt;
        @(negedge clk);
        evt[1] = 1'b0;
        repeat (3) @(negedge clk);
        compared++; if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_unmasked_wrap: got %b expected 0", irq); end
        rd(A_OVF, d);
        compared++; if (d !== 32'h2) begin mismatched++; $display("[TB] FAIL irq_ovf_ch1: got %h expected 2", d); end
    endtask
`endif

    initial begin
        test_reset();
        test_counting();
        test_hi_lo();
        test_overflow();
        test_freeze_clear();
        test_bus_map();
`ifdef ABACUS_OVF_IRQ_EN
        test_irq();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
